// File: rtl/zb_ppdu_framer.sv
// zb_ppdu_framer: builds an IEEE 802.15.4 PPDU (preamble, SFD, PHR, payload[, FCS]) as 4-bit nibbles for inFIFO.
// Latency: first preamble nibble is written the cycle after an accepted inStart; one nibble per cycle when unstalled.
// Backpressure: inFull blocks the write in the same cycle and freezes state/counters; a starved byte source stalls PAYLOAD.
// Optional FCS: define ZB_FRAMER_FCS_EN to append a CRC-16 ITU-T FCS (inLength then counts the two FCS bytes).
module zb_ppdu_framer #(
  parameter int         PREAMBLE_NIBBLES = 8,
  parameter logic [7:0] SFD_BYTE         = 8'hA7,
  parameter int         MAX_LEN          = 127
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inStart,
  input  logic [6:0] inLength,
  input  logic [7:0] inByte,
  input  logic       inByteValid,
  output logic       outByteReady,
  input  logic       inFull,
  output logic [3:0] outData,
  output logic       outWriteEnable,
  output logic       outBusy,
  output logic       outDone,
  output logic       outError
);

  // Nibble counter must cover the preamble and the four FCS nibbles.
  localparam int         NCW       = (PREAMBLE_NIBBLES > 4) ? $clog2(PREAMBLE_NIBBLES) : 2;
  localparam logic [NCW-1:0] PRE_LAST  = NCW'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PHR,
    PAYLOAD,
`ifdef ZB_FRAMER_FCS_EN
    FCS,
`endif
    DONE
  } state_t;

  state_t         state;
  logic [6:0]     lenReg;
  logic [6:0]     payloadLen;
  logic [6:0]     byteCnt;
  logic [NCW-1:0] nibCnt;
  logic [7:0]     holdByte;
  logic           haveByte;
  logic           pending;
  logic [3:0]     nibble;
  logic           acceptByte;
  logic           lengthLegal;

`ifdef ZB_FRAMER_FCS_EN
  logic [15:0] crcReg;
  logic [15:0] crcNext;

  // Reflected CRC-16 ITU-T (0x1021 reversed = 0x8408) stepped over one byte, LSB first.
  always_comb begin
    crcNext = crcReg;
    for (int i = 0; i < 8; i++) begin
      if (crcNext[0] ^ inByte[i]) crcNext = (crcNext >> 1) ^ 16'h8408;
      else                        crcNext = crcNext >> 1;
    end
  end

  assign payloadLen  = lenReg - 7'd2;
  assign lengthLegal = (inLength >= 7'd2) && ({1'b0, inLength} <= MAX_LEN_W);
`else
  assign payloadLen  = lenReg;
  assign lengthLegal = (inLength != 7'd0) && ({1'b0, inLength} <= MAX_LEN_W);
`endif

  // Byte handshake is independent of inFull; the holding register decouples source from FIFO.
  assign outByteReady = (state == PAYLOAD) && !haveByte && (byteCnt < payloadLen);
  assign acceptByte   = outByteReady && inByteValid;

  // Select the nibble owed in the current state; low nibble of every byte goes first.
  always_comb begin
    pending = 1'b0;
    nibble  = 4'h0;
    case (state)
      PREAMBLE: pending = 1'b1;
      SFD: begin
        pending = 1'b1;
        nibble  = nibCnt[0] ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
      end
      PHR: begin
        pending = 1'b1;
        nibble  = nibCnt[0] ? {1'b0, lenReg[6:4]} : lenReg[3:0];
      end
      PAYLOAD: begin
        pending = haveByte;
        nibble  = nibCnt[0] ? holdByte[7:4] : holdByte[3:0];
      end
`ifdef ZB_FRAMER_FCS_EN
      FCS: begin
        pending = 1'b1;
        case (nibCnt[1:0])
          2'd0:    nibble = crcReg[3:0];
          2'd1:    nibble = crcReg[7:4];
          2'd2:    nibble = crcReg[11:8];
          default: nibble = crcReg[15:12];
        endcase
      end
`endif
      default: ;
    endcase
  end

  // Strobe is a decode of registered state gated by inFull, so a full FIFO blocks the very cycle it is seen.
  assign outWriteEnable = pending && !inFull;
  assign outData        = pending ? nibble : 4'h0;

  // Frame sequencer: advances only on a completed nibble write, captures payload bytes on handshake.
  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state    <= IDLE;
      lenReg   <= '0;
      byteCnt  <= '0;
      nibCnt   <= '0;
      holdByte <= '0;
      haveByte <= 1'b0;
      outBusy  <= 1'b0;
      outDone  <= 1'b0;
      outError <= 1'b0;
`ifdef ZB_FRAMER_FCS_EN
      crcReg   <= '0;
`endif
    end else begin
      outDone  <= 1'b0;
      outError <= 1'b0;
      if (acceptByte) begin
        holdByte <= inByte;
        haveByte <= 1'b1;
        byteCnt  <= byteCnt + 7'd1;
`ifdef ZB_FRAMER_FCS_EN
        crcReg   <= crcNext;
`endif
      end
      case (state)
        IDLE: begin
          if (inStart) begin
            if (lengthLegal) begin
              lenReg   <= inLength;
              byteCnt  <= '0;
              nibCnt   <= '0;
              haveByte <= 1'b0;
`ifdef ZB_FRAMER_FCS_EN
              crcReg   <= '0;
`endif
              outBusy  <= 1'b1;
              state    <= PREAMBLE;
            end else begin
              outError <= 1'b1;
            end
          end
        end
        PREAMBLE: begin
          if (outWriteEnable) begin
            if (nibCnt == PRE_LAST) begin
              nibCnt <= '0;
              state  <= SFD;
            end else begin
              nibCnt <= nibCnt + NCW'(1);
            end
          end
        end
        SFD: begin
          if (outWriteEnable) begin
            if (nibCnt[0]) begin
              nibCnt <= '0;
              state  <= PHR;
            end else begin
              nibCnt <= NCW'(1);
            end
          end
        end
        PHR: begin
          if (outWriteEnable) begin
            if (nibCnt[0]) begin
              nibCnt <= '0;
`ifdef ZB_FRAMER_FCS_EN
              // A length of 2 carries only the FCS.
              if (payloadLen == 7'd0) state <= FCS;
              else                    state <= PAYLOAD;
`else
              state  <= PAYLOAD;
`endif
            end else begin
              nibCnt <= NCW'(1);
            end
          end
        end
        PAYLOAD: begin
          if (outWriteEnable) begin
            if (nibCnt[0]) begin
              nibCnt   <= '0;
              haveByte <= 1'b0;
              if (byteCnt == payloadLen) begin
`ifdef ZB_FRAMER_FCS_EN
                state   <= FCS;
`else
                state   <= DONE;
                outBusy <= 1'b0;
                outDone <= 1'b1;
`endif
              end
            end else begin
              nibCnt <= NCW'(1);
            end
          end
        end
`ifdef ZB_FRAMER_FCS_EN
        FCS: begin
          if (outWriteEnable) begin
            if (nibCnt[1:0] == 2'd3) begin
              nibCnt  <= '0;
              state   <= DONE;
              outBusy <= 1'b0;
              outDone <= 1'b1;
            end else begin
              nibCnt <= nibCnt + NCW'(1);
            end
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zb_ppdu_framer.sv
// tb_zb_ppdu_framer: scoreboard bench for zb_ppdu_framer (nibble order, backpressure, source stall, errors, reset).
// Expected nibbles are queued when a frame is set up and popped on every DUT write strobe.
// Build with +define+ZB_FRAMER_FCS_EN to exercise the FCS variant.
module tb_zb_ppdu_framer;

  logic       inClock = 1'b0;
  logic       inReset;
  logic       inStart;
  logic [6:0] inLength;
  logic [7:0] inByte;
  logic       inByteValid;
  logic       outByteReady;
  logic       inFull;
  logic [3:0] outData;
  logic       outWriteEnable;
  logic       outBusy;
  logic       outDone;
  logic       outError;

  always #5 inClock = ~inClock;

  zb_ppdu_framer dut (
    .inClock(inClock),
    .inReset(inReset),
    .inStart(inStart),
    .inLength(inLength),
    .inByte(inByte),
    .inByteValid(inByteValid),
    .outByteReady(outByteReady),
    .inFull(inFull),
    .outData(outData),
    .outWriteEnable(outWriteEnable),
    .outBusy(outBusy),
    .outDone(outDone),
    .outError(outError)
  );

  typedef logic [7:0] byteQ_t[$];

  int errCount = 0;
  int checkCount = 0;

  logic [3:0] expQ[$];
  logic [7:0] srcQ[$];
  int         fullAt[$];

  int  cycle = 0;
  int  writeCount = 0;
  int  lastWrite = 0;
  int  doneCount = 0;
  int  errPulses = 0;
  int  gapCycles = 0;
  int  srcSent = 0;
  int  fullLeft = 0;
  int  gapLeft = 0;
  bit  gapEnable = 0;
  bit  gapWait = 0;
  bit  prevDone = 0;
  bit  prevErr = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue the nibbles a frame should produce and the bytes the source will offer.
  task automatic pushFrame(input logic [6:0] len, input byteQ_t b, input logic [15:0] fcs);
    for (int i = 0; i < 8; i++) expQ.push_back(4'h0);
    expQ.push_back(4'h7);
    expQ.push_back(4'hA);
    expQ.push_back(len[3:0]);
    expQ.push_back({1'b0, len[6:4]});
    foreach (b[i]) begin
      expQ.push_back(b[i][3:0]);
      expQ.push_back(b[i][7:4]);
      srcQ.push_back(b[i]);
    end
`ifdef ZB_FRAMER_FCS_EN
    expQ.push_back(fcs[3:0]);
    expQ.push_back(fcs[7:4]);
    expQ.push_back(fcs[11:8]);
    expQ.push_back(fcs[15:12]);
`else
    if (fcs != 16'h0) $display("note: fcs argument ignored without FCS");
`endif
  endtask

  task automatic startFrame(input logic [6:0] len, input bit expectGo);
    writeCount = 0;
    srcSent    = 0;
    @(posedge inClock); #1;
    inStart  = 1'b1;
    inLength = len;
    @(posedge inClock); #1;
    inStart  = 1'b0;
    #1;
    if (expectGo) begin
      checkVal("busyAfterStart", outBusy, 1);
      checkVal("firstWriteLatency", outWriteEnable, 1);
      checkVal("firstNibble", outData, 0);
    end else begin
      checkVal("busyAfterBadStart", outBusy, 0);
      checkVal("errorAfterBadStart", outError, 1);
    end
  endtask

  task automatic waitDone(input string tag);
    int d0;
    d0 = doneCount;
    for (int i = 0; i < 400 && doneCount == d0; i++) @(negedge inClock);
    checkVal({tag, "_done"}, doneCount - d0, 1);
    repeat (2) @(negedge inClock);
    checkVal({tag, "_leftNibbles"}, expQ.size(), 0);
    checkVal({tag, "_leftBytes"}, srcQ.size(), 0);
    expQ.delete();
    srcQ.delete();
    fullAt.delete();
  endtask

  // Bus agent: monitor outputs at negedge, drive source/full at posedge+1.
  initial begin : agent
    bit fire;
    forever begin
      @(negedge inClock);
      cycle++;
      if (inReset) begin
        checkVal("writeInReset", outWriteEnable, 0);
      end else begin
        if (inFull) checkVal("writeWhileFull", outWriteEnable, 0);
        if (outWriteEnable) begin
          checkVal("busyOnWrite", outBusy, 1);
          if (expQ.size() == 0) checkVal("extraWrite", {28'd0, outData}, 32'hFFFF_FFFF);
          else                  checkVal("nibble", outData, expQ.pop_front());
          writeCount++;
          lastWrite = cycle;
        end
        if (prevDone) checkVal("donePulseWidth", outDone, 0);
        if (outDone) begin
          doneCount++;
          checkVal("doneAfterLastWrite", cycle - lastWrite, 1);
          checkVal("busyAtDone", outBusy, 0);
        end
        if (prevErr) checkVal("errorPulseWidth", outError, 0);
        if (outError) errPulses++;
      end
      prevDone = outDone;
      prevErr  = outError;
      if (gapWait && outByteReady) begin
        gapWait = 0;
        gapLeft = 5;
      end
      if (gapLeft > 0) begin
        gapCycles++;
        checkVal("gapReady", outByteReady, 1);
        checkVal("gapNoWrite", outWriteEnable, 0);
      end
      fire = inByteValid && outByteReady && !inReset;
      if (fullLeft == 0 && fullAt.size() > 0 && writeCount == fullAt[0]) begin
        void'(fullAt.pop_front());
        fullLeft = 3;
      end
      @(posedge inClock); #1;
      if (fire && srcQ.size() > 0) begin
        void'(srcQ.pop_front());
        srcSent++;
        if (gapEnable && srcSent == 1) begin
          gapEnable = 0;
          gapWait   = 1;
        end
      end
      if (gapLeft > 0) gapLeft--;
      if (fullLeft > 0) begin
        inFull = 1'b1;
        fullLeft--;
      end else begin
        inFull = 1'b0;
      end
      inByteValid = (srcQ.size() > 0) && !gapWait && (gapLeft == 0);
      inByte      = (srcQ.size() > 0) ? srcQ[0] : 8'h00;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errCount, checkCount);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e0;
    inReset     = 1'b1;
    inStart     = 1'b0;
    inLength    = 7'd0;
    inByte      = 8'h00;
    inByteValid = 1'b0;
    inFull      = 1'b0;
    repeat (3) @(posedge inClock);
    #2;
    checkVal("rst_we", outWriteEnable, 0);
    checkVal("rst_busy", outBusy, 0);
    checkVal("rst_done", outDone, 0);
    checkVal("rst_error", outError, 0);
    checkVal("rst_ready", outByteReady, 0);
    checkVal("rst_data", outData, 0);
    @(posedge inClock); #1;
    inReset = 1'b0;

`ifndef ZB_FRAMER_FCS_EN
    // Basic frame: 0x8 x0, 7, A, 2, 0, C, 3, A, 5.
    pushFrame(7'd2, '{8'h3C, 8'h5A}, 16'h0);
    startFrame(7'd2, 1);
    waitDone("basic");

    // Full asserted during SFD high nibble and between payload nibbles.
    fullAt = '{9, 13};
    pushFrame(7'd2, '{8'h3C, 8'h5A}, 16'h0);
    startFrame(7'd2, 1);
    waitDone("backpressure");

    // Source withholds the second byte for 5 ready cycles.
    gapCycles = 0;
    gapEnable = 1;
    pushFrame(7'd2, '{8'h3C, 8'h5A}, 16'h0);
    startFrame(7'd2, 1);
    waitDone("stall");
    checkVal("stallCycles", gapCycles, 5);

    // Zero length is rejected.
    e0 = errPulses;
    startFrame(7'd0, 0);
    repeat (4) @(negedge inClock);
    checkVal("len0_errorPulses", errPulses - e0, 1);
    checkVal("len0_busy", outBusy, 0);

    // inStart while busy is ignored; max-length bytes still framed for a 1-byte frame.
    e0 = errPulses;
    pushFrame(7'd1, '{8'h96}, 16'h0);
    startFrame(7'd1, 1);
    repeat (3) @(posedge inClock);
    #1;
    inStart  = 1'b1;
    inLength = 7'd100;
    @(posedge inClock); #1;
    inStart  = 1'b0;
    waitDone("busyStart");
    checkVal("busyStart_noError", errPulses - e0, 0);
`else
    // FCS over a single 0x00 byte is 0x0000.
    pushFrame(7'd3, '{8'h00}, 16'h0000);
    startFrame(7'd3, 1);
    waitDone("fcsZero");

    // FCS over a single 0x01 byte is 0x1189.
    pushFrame(7'd3, '{8'h01}, 16'h1189);
    startFrame(7'd3, 1);
    waitDone("fcsOne");

    // Length 2 carries only the FCS of an empty payload.
    pushFrame(7'd2, '{}, 16'h0000);
    startFrame(7'd2, 1);
    waitDone("fcsEmpty");

    // Lengths below 2 are rejected.
    e0 = errPulses;
    startFrame(7'd1, 0);
    repeat (4) @(negedge inClock);
    checkVal("len1_errorPulses", errPulses - e0, 1);
    checkVal("len1_busy", outBusy, 0);
`endif

    // Reset in the middle of the payload abandons the frame.
    pushFrame(7'd4, '{8'h11, 8'h22, 8'h33, 8'h44}, 16'h0);
    startFrame(7'd4, 1);
    for (int i = 0; i < 100 && writeCount < 13; i++) @(posedge inClock);
    checkVal("reachedPayload", (writeCount >= 13) ? 1 : 0, 1);
    #2;
    inReset = 1'b1;
    #1;
    checkVal("midRst_we", outWriteEnable, 0);
    checkVal("midRst_busy", outBusy, 0);
    checkVal("midRst_ready", outByteReady, 0);
    expQ.delete();
    srcQ.delete();
    fullAt.delete();
    repeat (3) @(posedge inClock);
    #2;
    inReset = 1'b0;

    // Clean frame after the reset.
`ifndef ZB_FRAMER_FCS_EN
    pushFrame(7'd2, '{8'h3C, 8'h5A}, 16'h0);
    startFrame(7'd2, 1);
`else
    pushFrame(7'd3, '{8'h01}, 16'h1189);
    startFrame(7'd3, 1);
`endif
    waitDone("afterReset");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
